// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 8-bit CPU front end: opcodes, instruction field
// positions, the fetch-state encoding and the PC step.
package cpu_defs_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNEQ  = 8'h08;

  localparam int INSTR_WIDTH  = 32;
  localparam int OPCODE_MSB   = 31;
  localparam int OPCODE_LSB   = 24;
  localparam int OFFSET_MSB   = 23;
  localparam int OFFSET_LSB   = 16;
  localparam int OFFSET_WIDTH = OFFSET_MSB - OFFSET_LSB + 1;
  localparam int RT_MSB       = 15;
  localparam int RT_LSB       = 8;
  localparam int RS_MSB       = 7;
  localparam int RS_LSB       = 0;

  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    EXEC  = 2'd3
  } fetch_state_t;

  function automatic logic is_flow_op(input logic [7:0] op);
    return (op == OP_J) || (op == OP_BEQ) || (op == OP_BNEQ);
  endfunction

endpackage

// File: rtl/pc_target_adder.sv
// Sequential and branch-target PC arithmetic (wraps modulo 2^PC_WIDTH).
// CPU_UNIT_DELAY_EN adds lab-style propagation delays to both adders.
module pc_target_adder
  import cpu_defs_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic [OFFSET_WIDTH-1:0] offset,
  output logic [PC_WIDTH-1:0]     pc_plus4,
  output logic [PC_WIDTH-1:0]     target
);

  // OFFSET counts instruction words, so scale by 4 after sign extension.
  logic [PC_WIDTH-1:0] byte_offset;
  assign byte_offset = {{(PC_WIDTH-OFFSET_WIDTH-2){offset[OFFSET_WIDTH-1]}}, offset, 2'b00};

`ifdef CPU_UNIT_DELAY_EN
  assign #1 pc_plus4 = pc + PC_WIDTH'(PC_STEP);
  assign #2 target   = pc_plus4 + byte_offset;
`else
  assign pc_plus4 = pc + PC_WIDTH'(PC_STEP);
  assign target   = pc_plus4 + byte_offset;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, IMEM request handshake and next-PC select.
// CPU_UNIT_DELAY_EN models lab delays on the PC update and instruction latch.
`ifdef CPU_UNIT_DELAY_EN
  `define FU_PC_DLY #1
  `define FU_IR_DLY #2
`else
  `define FU_PC_DLY
  `define FU_IR_DLY
`endif

module pc_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter int                  PC_WIDTH        = 32,
  parameter int                  IMEM_ADDR_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       IMEM_BUSYWAIT,
  input  logic [INSTR_WIDTH-1:0]     IMEM_READDATA,
  output logic                       IMEM_READ,
  output logic [IMEM_ADDR_WIDTH-1:0] IMEM_ADDRESS,
  input  logic                       DMEM_BUSYWAIT,
  input  logic                       J,
  input  logic                       BEQ,
  input  logic                       BNEQ,
  input  logic                       ZERO,
  output logic [INSTR_WIDTH-1:0]     INSTRUCTION,
  output logic                       INSTR_VALID,
  output logic [PC_WIDTH-1:0]        PC
);

  fetch_state_t           state_reg;
  logic [PC_WIDTH-1:0]    pc_reg;
  logic [INSTR_WIDTH-1:0] instr_reg;
  logic                   imem_read_reg;
  logic                   instr_valid_reg;

  logic [PC_WIDTH-1:0]    pc_plus4;
  logic [PC_WIDTH-1:0]    target;
  logic [PC_WIDTH-1:0]    pc_next;
  logic                   taken;

  pc_target_adder #(
    .PC_WIDTH (PC_WIDTH)
  ) u_target_adder (
    .pc       (pc_reg),
    .offset   (instr_reg[OFFSET_MSB:OFFSET_LSB]),
    .pc_plus4 (pc_plus4),
    .target   (target)
  );

  assign taken   = J | (BEQ & ZERO) | (BNEQ & ~ZERO);
  assign pc_next = taken ? target : pc_plus4;

  // Branch controls only matter on the EXEC exit edge; elsewhere they are ignored.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      instr_reg       <= '0;
      imem_read_reg   <= 1'b0;
      instr_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          state_reg     <= FETCH;
          imem_read_reg <= 1'b1;
        end
        FETCH: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (!IMEM_BUSYWAIT) begin
            instr_reg       <= `FU_IR_DLY IMEM_READDATA;
            imem_read_reg   <= 1'b0;
            instr_valid_reg <= 1'b1;
            state_reg       <= EXEC;
          end
        end
        EXEC: begin
          if (!DMEM_BUSYWAIT) begin
            pc_reg          <= `FU_PC_DLY pc_next;
            instr_valid_reg <= 1'b0;
            imem_read_reg   <= 1'b1;
            state_reg       <= FETCH;
          end
        end
        default: begin
          state_reg       <= BOOT;
          imem_read_reg   <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_READ    = imem_read_reg;
  assign IMEM_ADDRESS = pc_reg[IMEM_ADDR_WIDTH-1:0];
  assign INSTRUCTION  = instr_reg;
  assign INSTR_VALID  = instr_valid_reg;
  assign PC           = pc_reg;

endmodule

`undef FU_PC_DLY
`undef FU_IR_DLY

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the control unit in the single-issue 8-bit CPU.
- Holds the program counter and runs a fetch handshake with the instruction memory/cache.
- Latches the 32-bit instruction whose OPCODE, register and OFFSET fields drive decode.
- Consumes the decoded J/BEQ/BNEQ signals plus ALU ZERO to select the next PC.

Parameters:
- PC_WIDTH, 32, width of the program counter and address arithmetic.
- IMEM_ADDR_WIDTH, 10, byte-address bits driven to instruction memory (PC[IMEM_ADDR_WIDTH-1:0]).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IMEM_BUSYWAIT  input  1  instruction memory busy; the read data is valid when this is low after a request.
- IMEM_READDATA  input  32  instruction word from instruction memory.
- IMEM_READ  output  1  instruction read request.
- IMEM_ADDRESS  output  IMEM_ADDR_WIDTH  byte address of the requested instruction.
- DMEM_BUSYWAIT  input  1  data-memory stall; holds the execute phase.
- J  input  1  unconditional jump, from decode.
- BEQ  input  1  branch if equal, from decode.
- BNEQ  input  1  branch if not equal, from decode.
- ZERO  input  1  ALU result-is-zero flag.
- INSTRUCTION  output  32  latched instruction; OPCODE = [31:24], OFFSET = [23:16].
- INSTR_VALID  output  1  high while INSTRUCTION is being executed.
- PC  output  PC_WIDTH  current program counter.

Behaviour:
- Reset values (asynchronous, immediate on RESET high):
  - PC = RESET_PC; INSTRUCTION = 0; INSTR_VALID = 0; IMEM_READ = 0; state = BOOT.
  - Reset mid-fetch drops IMEM_READ immediately. Any returning data is ignored.
- State BOOT: one cycle after reset deasserts -> FETCH.
- State FETCH:
  - IMEM_READ = 1, IMEM_ADDRESS = PC[IMEM_ADDR_WIDTH-1:0].
  - Next edge -> WAIT.
- State WAIT:
  - IMEM_READ stays 1.
  - On an edge with IMEM_BUSYWAIT = 0: latch IMEM_READDATA into INSTRUCTION, drop IMEM_READ, go to EXEC.
  - Otherwise stay in WAIT.
  - Cache hit (busywait never rises) costs one WAIT cycle. Minimum fetch-to-exec latency is 2 cycles.
- State EXEC:
  - INSTR_VALID = 1; INSTRUCTION is stable; decode, ALU and register file evaluate.
  - If DMEM_BUSYWAIT = 1 on the edge: stay in EXEC, PC unchanged.
  - Else: PC <= next_pc, then -> FETCH.
  - INSTR_VALID is high for exactly the EXEC cycles of each instruction.
- Next-PC arithmetic (all PC_WIDTH bits, wrap modulo 2^PC_WIDTH):
  - pc_plus4 = PC + 4.
  - target = pc_plus4 + (sign-extended OFFSET << 2). OFFSET is a signed instruction-word count.
  - taken = J | (BEQ & ZERO) | (BNEQ & ~ZERO).
  - next_pc = taken ? target : pc_plus4.
- Boundaries:
  - OFFSET = 8'hFF with taken = 1 re-executes the same instruction (target = PC).
  - OFFSET = 8'h80 jumps back 128 words.
  - PC wrap past the maximum is silent. No exception is raised.
  - J, BEQ and BNEQ are sampled only on the EXEC exit edge. Values in other states are ignored.
  - If several of J/BEQ/BNEQ are high at once, the OR rule above applies.
  - J/BEQ/BNEQ/ZERO undefined (X) during EXEC is a verification error; the bench must flag it.
  - IMEM_BUSYWAIT high in FETCH has no effect.

Optional Feature:
- Macro CPU_UNIT_DELAY_EN.
- Defined: models the lab timing delays.
  - PC register update #1 after the edge.
  - pc_plus4 adder #1.
  - Branch-target adder #2.
  - INSTRUCTION latch #2.
  - Zero-delay equivalence is not required.
- Undefined: all paths are zero-delay; the block is synthesizable.
- Cycle-level state sequencing is identical in both builds.

Decomposition:
- Shared package cpu_defs_pkg:
  - Opcode constants: LOADI = 8'h00, MOV, ADD, SUB, AND, OR, J = 8'h06, BEQ = 8'h07, BNEQ = 8'h08.
  - Instruction field bit positions.
  - Fetch-state enum {BOOT, FETCH, WAIT, EXEC}.
  - PC_STEP = 4.
- One sub-module: pc_target_adder. It computes pc_plus4 and target from PC and OFFSET, and is reused by the verification model.

Test Plan:
- Reset then IMEM_BUSYWAIT = 0 with IMEM_READDATA = 32'h0000_0105 -> IMEM_ADDRESS = 0 in FETCH; INSTRUCTION = 32'h0000_0105 and INSTR_VALID = 1 two cycles after FETCH; PC = 4 after EXEC.
- IMEM_BUSYWAIT held high for 5 cycles -> stays in WAIT with IMEM_READ = 1 and PC unchanged; latches on the first low-busywait edge.
- PC = 8, J = 1, OFFSET = 8'h02 -> PC = 20. PC = 20, J = 1, OFFSET = 8'hFD -> PC = 12.
- PC = 0, BEQ = 1: ZERO = 1 with OFFSET = 8'h03 -> PC = 16; ZERO = 0 -> PC = 4. BNEQ = 1: the same two cases give the inverse results.
- DMEM_BUSYWAIT high for 3 EXEC cycles -> INSTR_VALID high 4 cycles, one PC update only.
- RESET pulsed while in WAIT at PC = 40 -> PC = 0, IMEM_READ = 0 and INSTR_VALID = 0 immediately (asynchronous); fetch restarts at address 0.
